ps2_tx: RTL and testbench

PS2_TX -- requirements
Module: ps2_tx

---
 rtl/ps2_tx.sv | 193 +++++++++++++++++++
 tb/tb_ps2_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 command transmitter.
//   Accepts one byte (valid_i && ready_o), inhibits the bus by holding the
//   clock low, issues the start bit, then shifts data/parity/stop on the
//   device's falling clock edges and checks the device ACK on edge 11.
// Ports:
//   clk_i, reset_i                     system clock, async active-high reset
//   data_i[7:0], valid_i, ready_o      command byte handshake
//   ps2_clk_async_i, ps2_data_async_i  raw PS/2 line levels
//   ps2_clk_oe_o, ps2_data_oe_o        1 = pull line low (open drain)
//   busy_o                             frame in progress
//   done_o / error_o                   one-cycle result pulses
module ps2_tx #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int INHIBIT_US    = 120,
  parameter int TIMEOUT_US    = 15000,
  parameter int FILTER_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  input  logic       ps2_clk_async_i,
  input  logic       ps2_data_async_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o
);

  localparam int    INH_CYC = CLK_FREQ_HZ / 1_000_000 * INHIBIT_US;
  // 64-bit so the product cannot overflow before the divide
  localparam longint TO_CYC = longint'(TIMEOUT_US) * longint'(CLK_FREQ_HZ) / 1_000_000;
  localparam int    INH_W   = (INH_CYC > 1) ? $clog2(INH_CYC) : 1;
  localparam int    TO_W    = $clog2(TO_CYC + 1);
  localparam int    FLT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam int    BIT_W   = $clog2(11);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_SHIFT, S_ACK, S_RECOVER
  } state_t;

  state_t r_state, w_next;

  // ---------------- line conditioning: [0]=clock, [1]=data ----------------
  logic [1:0]            w_async;
  logic [1:0]            r_meta, r_sync, r_filt;
  logic [1:0][FLT_W-1:0] r_fcnt;
  logic                  r_clk_d;

  assign w_async = {ps2_data_async_i, ps2_clk_async_i};

  // A new level is taken only after FILTER_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_meta  <= '1;
      r_sync  <= '1;
      r_filt  <= '1;
      r_fcnt  <= '0;
      r_clk_d <= 1'b1;
    end else begin
      r_meta  <= w_async;
      r_sync  <= r_meta;
      r_clk_d <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FLT_W'(FILTER_CYCLES - 1)) begin
          r_filt[i] <= r_sync[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  logic w_clk_f, w_dat_f, w_clk_fall, w_clk_edge, w_lines_hi;
  assign w_clk_f    = r_filt[0];
  assign w_dat_f    = r_filt[1];
  assign w_clk_fall = r_clk_d & ~w_clk_f;
  assign w_clk_edge = r_clk_d ^ w_clk_f;
  assign w_lines_hi = w_clk_f & w_dat_f;

  // ---------------- datapath ----------------
  logic [9:0]       r_sh;      // {stop, parity, data}, shifted out LSB first
  logic             r_dout;    // frame bit currently on the data line
  logic [BIT_W-1:0] r_bcnt;
  logic [INH_W-1:0] r_inh_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_nack;
  logic             w_timing, w_timeout, w_inh_last;

  assign w_timing   = (r_state == S_START) || (r_state == S_SHIFT) || (r_state == S_ACK);
  assign w_timeout  = w_timing && (r_to_cnt == TO_W'(TO_CYC));
  assign w_inh_last = (r_inh_cnt == INH_W'(INH_CYC - 1));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sh      <= '0;
      r_dout    <= 1'b1;
      r_bcnt    <= '0;
      r_inh_cnt <= '0;
      r_to_cnt  <= '0;
      r_nack    <= 1'b0;
    end else begin
      // Any filtered clock edge, including the one from our own release,
      // counts as bus activity.
      r_to_cnt <= (!w_timing || w_clk_edge) ? '0 : r_to_cnt + 1'b1;
      unique case (r_state)
        S_IDLE: begin
          r_inh_cnt <= '0;
          if (valid_i) r_sh <= {1'b1, ~^data_i, data_i};
        end
        S_INHIBIT: r_inh_cnt <= r_inh_cnt + 1'b1;
        S_START: begin
          r_bcnt <= '0;
          r_dout <= 1'b0;
        end
        S_SHIFT: begin
          if (w_clk_fall) begin
            r_dout <= r_sh[0];
            r_sh   <= {1'b1, r_sh[9:1]};
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_ACK:     if (w_clk_fall) r_nack <= w_dat_f;
        S_RECOVER: ;
        default:   ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (valid_i) w_next = S_INHIBIT;
      S_INHIBIT: if (w_inh_last) w_next = S_START;
      S_START:   w_next = w_timeout ? S_IDLE : S_SHIFT;
      S_SHIFT: begin
        if (w_timeout) w_next = S_IDLE;
        else if (w_clk_fall && r_bcnt == BIT_W'(9)) w_next = S_ACK;
      end
      S_ACK: begin
        if (w_timeout) w_next = S_IDLE;
        else if (w_clk_fall) w_next = S_RECOVER;
      end
      S_RECOVER: if (w_lines_hi) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o       = 1'b0;
    busy_o        = 1'b1;
    ps2_clk_oe_o  = 1'b0;
    ps2_data_oe_o = 1'b0;
    done_o        = 1'b0;
    error_o       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        busy_o  = 1'b0;
      end
      S_INHIBIT: begin
        ps2_clk_oe_o  = 1'b1;
        ps2_data_oe_o = w_inh_last;   // start bit goes out on the last inhibit cycle
      end
      S_START: begin
        ps2_data_oe_o = ~w_timeout;
        error_o       = w_timeout;
      end
      S_SHIFT: begin
        ps2_data_oe_o = ~r_dout & ~w_timeout;
        error_o       = w_timeout;
      end
      S_ACK: error_o = w_timeout;
      S_RECOVER: begin
        done_o  = w_lines_hi & ~r_nack;
        error_o = w_lines_hi &  r_nack;
      end
      default: busy_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks frames out of the DUT,
// a scoreboard queue holds the expected outcome of every issued byte and a
// separate monitor compares on each done_o/error_o pulse.
module tb_ps2_tx;
  localparam int CLK_HZ = 1_000_000;   // 1 cycle per microsecond
  localparam int INH_US = 20;
  localparam int TO_US  = 400;
  localparam int FILT   = 8;
  localparam int TO_CYC = 400;
  localparam int HALF   = 30;          // device clock half period, cycles

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o, ps2_clk_oe_o, ps2_data_oe_o, busy_o, done_o, error_o;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk, ps2_data;

  // open-drain wired-AND of host and device
  assign ps2_clk  = ~(ps2_clk_oe_o  | dev_clk_low);
  assign ps2_data = ~(ps2_data_oe_o | dev_data_low);

  always #5 clk_i = ~clk_i;

  ps2_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_US(TO_US),
           .FILTER_CYCLES(FILT)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .ps2_clk_async_i(ps2_clk), .ps2_data_async_i(ps2_data),
    .ps2_clk_oe_o(ps2_clk_oe_o), .ps2_data_oe_o(ps2_data_oe_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o));

  typedef struct {
    logic       is_err;
    logic       chk_frame;
    logic       chk_to;
    logic [9:0] frame;     // frame[n-1] = bit seen by device after falling edge n
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0, failures = 0;
  int         cyc = 0;
  int         t_start = 0;
  logic [9:0] cap = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    int   lat;
    logic prev_clk_oe;
    logic want_ready;
    prev_clk_oe = 1'b0;
    want_ready  = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!reset_i) begin
        if (want_ready) begin
          check("ready_after_pulse", ready_o, 1);
          want_ready = 1'b0;
        end
        if (busy_o && prev_clk_oe && !ps2_clk_oe_o) t_start = cyc;
        if (done_o || error_o) begin
          check("pulse_exclusive", done_o & error_o, 0);
          check("lines_released_at_pulse", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {done_o, error_o}, 0);
          end else begin
            e = exp_q.pop_front();
            check("error_pulse", error_o, e.is_err);
            check("done_pulse", done_o, !e.is_err);
            if (e.chk_frame) check("frame_bits", cap, e.frame);
            if (e.chk_to) begin
              // the host's own clock release is seen as a filtered edge and
              // reloads the counter, so allow one filter latency of slack
              lat = cyc - t_start;
              checks++;
              if (lat < TO_CYC || lat > TO_CYC + FILT + 4) begin
                failures++;
                $display("FAIL timeout_latency: got %0d cycles expected %0d..%0d",
                         lat, TO_CYC, TO_CYC + FILT + 4);
              end
            end
          end
          want_ready = 1'b1;
        end
      end
      prev_clk_oe = ps2_clk_oe_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!ready_o && n < 2000) begin @(posedge clk_i); #1; n++; end
    if (!ready_o) begin
      checks++; failures++;
      $display("FAIL ready_wait: ready_o still low after %0d cycles", n);
    end
    @(posedge clk_i); #1;
    data_i  = d;
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy_o && n < 3000) begin @(posedge clk_i); #1; n++; end
    if (busy_o) begin
      checks++; failures++;
      $display("FAIL idle_wait: busy_o still high after %0d cycles", n);
    end
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  // Device model: waits for the host to release the clock, then issues
  // nedges falling edges, sampling the data line late in each low phase.
  task automatic device(input int nedges, input logic ack_low, input logic glitch);
    int n = 0;
    while (!(busy_o && !ps2_clk_oe_o) && n < 500) begin @(posedge clk_i); #1; n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL device_wait_release: clock not released after %0d cycles", n);
      return;
    end
    cap = '0;
    repeat (40) @(posedge clk_i);
    #1;
    for (int k = 1; k <= nedges; k++) begin
      if (k == 11 && ack_low) begin
        dev_data_low = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk_i);
      #1;
      if (k <= 10) cap[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(posedge clk_i);
      #1;
      if (k == 11) dev_data_low = 1'b0;
      if (glitch && k == 3) begin
        dev_clk_low = 1'b1;          // 3-cycle spike, shorter than the filter
        repeat (3) @(posedge clk_i);
        #1;
        dev_clk_low = 1'b0;
        repeat (HALF) @(posedge clk_i);
        #1;
      end
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [9:0] f, input logic ack_low);
    exp_q.push_back('{is_err: !ack_low, chk_frame: 1'b1, chk_to: 1'b0, frame: f});
    send(d);
    device(11, ack_low, 1'b0);
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_ready", ready_o, 1);
    check("reset_busy", busy_o, 0);
    check("reset_oe", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
    check("reset_pulses", {done_o, error_o}, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;

    // ACK'd frames; frame = {stop, odd parity, data}
    frame(8'hED, 10'h3ED, 1'b1);
    frame(8'h01, 10'h201, 1'b1);
    frame(8'hFF, 10'h3FF, 1'b1);
    // device NACKs
    frame(8'hA5, 10'h3A5, 1'b0);

    // device never clocks
    exp_q.push_back('{is_err: 1'b1, chk_frame: 1'b0, chk_to: 1'b1, frame: '0});
    send(8'h55);
    wait_idle();

    // reset in the middle of a frame, after edge 5 (data bit 4 of 0xED = 0)
    send(8'hED);
    device(5, 1'b0, 1'b0);
    repeat (20) @(posedge clk_i);
    #1;
    check("midframe_busy", busy_o, 1);
    check("midframe_data_oe", ps2_data_oe_o, 1);
    @(posedge clk_i);
    #2;
    reset_i = 1'b1;
    #1;
    check("async_reset_oe", {ps2_clk_oe_o, ps2_data_oe_o}, 0);
    check("async_reset_ready", ready_o, 1);
    check("async_reset_busy", busy_o, 0);
    check("async_reset_pulses", {done_o, error_o}, 0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;

    // glitch on the clock plus a valid_i while busy
    exp_q.push_back('{is_err: 1'b0, chk_frame: 1'b1, chk_to: 1'b0, frame: 10'h33C});
    send(8'h3C);
    fork
      device(11, 1'b1, 1'b1);
      begin
        repeat (150) @(posedge clk_i);
        #1;
        data_i  = 8'h00;
        valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
      end
    join
    wait_idle();
    repeat (60) @(posedge clk_i);
    #1;
    check("no_queued_byte_busy", busy_o, 0);
    check("no_queued_byte_ready", ready_o, 1);

    repeat (10) @(posedge clk_i);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
